// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg
// N-stage, P-bit pipeline register chain with valid/ready handshaking.
// Words advance into empty downstream stages even while the consumer stalls,
// so up to N words are held before IN_READY drops. Strict FIFO order.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset (priority over everything)
//   FLUSH      synchronous active-high; clears all valid bits, data held
//   IN_VALID   producer presents IN_DATA
//   IN_READY   word accepted this cycle when IN_VALID is also high
//   IN_DATA    input word
//   OUT_VALID  OUT_DATA holds a valid word (last stage valid)
//   OUT_READY  consumer accepts OUT_DATA this cycle
//   OUT_DATA   last stage data register
//   OCC        registered count of valid stages, 0..N
module elastic_pipe_reg #(
    parameter int unsigned P = 32,
    parameter int unsigned N = 4,
    localparam int unsigned OW = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [P-1:0]  IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [P-1:0]  OUT_DATA,
    output logic [OW-1:0] OCC
);

    logic [N-1:0]  v_q, v_d;
    logic [N-1:0]  move;
    logic [P-1:0]  d_q [N];
    logic [P-1:0]  d_d [N];
    logic [OW-1:0] occ_q, occ_d;
    logic          acc;

    // Ready ripples from the output back to the input: a stage may move if
    // the next one is empty or is itself moving this cycle.
    always_comb begin
        move = '0;
        move[N-1] = v_q[N-1] & OUT_READY;
        for (int i = int'(N) - 2; i >= 0; i--) begin
            move[i] = v_q[i] & (~v_q[i+1] | move[i+1]);
        end
    end

    assign IN_READY = ~FLUSH & (~v_q[0] | move[0]);
    assign acc      = IN_VALID & IN_READY;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        v_d[0] = acc | (v_q[0] & ~move[0]);
        if (acc) begin
            d_d[0] = IN_DATA;
        end
        for (int i = 1; i < int'(N); i++) begin
            v_d[i] = move[i-1] | (v_q[i] & ~move[i]);
            if (move[i-1]) begin
                d_d[i] = d_q[i-1];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({acc, move[N-1]})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                d_q[i] <= '0;
            end
        end else if (FLUSH) begin
            // Valid bits drop; data registers keep their contents.
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            d_q   <= d_d;
        end
    end

    assign OUT_VALID = v_q[N-1];
    assign OUT_DATA  = d_q[N-1];
    assign OCC       = occ_q;

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
Parametrised N-stage, P-bit pipeline register chain with valid/ready handshaking, bubble collapsing and synchronous flush. It generalises the team's single enabled D register (RST/EN/D/Q) into a backpressure-aware delay line for datapath retiming between producer and consumer blocks. It reports its current occupancy.

Parameters:
P, 32, data width in bits.
N, 4, number of register stages (N >= 1); also the maximum number of words held.
OW, $clog2(N+1), occupancy counter width (derived, not overridden).

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
FLUSH  input  1  synchronous, active-high; discards all held words.
IN_VALID  input  1  producer presents IN_DATA.
IN_READY  output  1  block accepts IN_DATA this cycle.
IN_DATA  input  P  input word.
OUT_VALID  output  1  OUT_DATA holds a valid word.
OUT_READY  input  1  consumer accepts OUT_DATA this cycle.
OUT_DATA  output  P  output word (stage N-1 data register).
OCC  output  OW  number of valid stages, 0..N.

Behaviour:
- State per stage i (0..N-1): valid bit v[i], data register d[i]. Stage 0 is input side; stage N-1 drives OUT_VALID = v[N-1], OUT_DATA = d[N-1].
- Reset (RST=1 at edge): all v[i]=0, all d[i]=0, OCC=0. Outputs after reset: OUT_VALID=0, OUT_DATA=0, IN_READY=1, OCC=0. RST has priority over FLUSH and all handshakes.
- Move condition, evaluated combinationally:
  - move[N-1] = v[N-1] & OUT_READY.
  - move[i] = v[i] & (~v[i+1] | move[i+1]) for i < N-1.
- Ready:
  - IN_READY = ~FLUSH & (~v[0] | move[0]).
  - The ready path is a combinational chain through all N stages.
- Accept: acc = IN_VALID & IN_READY. On acc, d[0] <= IN_DATA and v[0] <= 1.
- Stage capture:
  - Stage i+1 captures d[i] when move[i]=1.
  - A stage emptied by move[i] with no incoming word clears v.
  - Data registers load only on capture and otherwise hold.
- Bubble collapse: with OUT_READY=0, words advance into empty downstream stages. Up to N words are stored before IN_READY drops.
- Latency: with an empty pipe and OUT_READY=1, a word accepted at edge t has OUT_VALID=1 in the cycle after edge t+N-1. N=1 gives a 1-cycle registered handshake.
- Throughput: 1 word/cycle sustained while OUT_READY=1. No bubbles are inserted.
- Ordering: strict FIFO order. No word is duplicated or dropped except by FLUSH/RST.
- OCC: registered count of valid stages, next = OCC + acc - move[N-1]. It never exceeds N and never underflows.
- Simultaneous full pipe, OUT_READY=1, IN_VALID=1: the output word leaves and the input word enters in the same edge. OCC stays N and IN_READY=1.
- FLUSH=1 at edge:
  - All v[i] <= 0 and OCC <= 0. d[i] hold their values.
  - IN_READY=0 during the FLUSH cycle, so no word is accepted.
  - OUT_VALID remains as registered during that cycle. A consumer handshake in that cycle completes normally, but the word is not re-presented.
- RST mid-operation: all held words are lost. The first post-reset accepted word appears after the full latency.
- Data is never modified in transit.

Test Plan:
- Reset: P=32, N=4, pulse RST 2 cycles with IN_VALID=1 -> OUT_VALID=0, OUT_DATA=0, OCC=0, IN_READY=1 after release.
- Streaming: OUT_READY=1, send 0x00000001..0x00000010 back-to-back -> first OUT_VALID 3 edges after first accept, 16 words in order, one per cycle, OCC steady at 4 (counts the in-flight words held in the 4 stages).
- Stall/fill: OUT_READY=0, IN_VALID=1 with 0xA0..0xA5 -> exactly 4 accepted (0xA0..0xA3), IN_READY=0 with OCC=4. Raise OUT_READY -> 0xA0..0xA5 delivered in order.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22 with OUT_READY=0 -> both stored contiguously, OCC=2, OUT_DATA=0x11. Release -> 0x11 then 0x22 on consecutive cycles.
- Flush: fill with 3 words, assert FLUSH one cycle with IN_VALID=1 -> IN_READY=0 that cycle, then OCC=0, OUT_VALID=0, and the flush-cycle input word never appears.
- N=1, P=8: random valid/ready (50% each) over 1000 words vs a scoreboard -> zero mismatches, OCC in {0,1}, full throughput when OUT_READY=1.
